// File: rtl/key_input_conditioner_pkg.sv
// Shared definitions for the push-button conditioning block.
// Contents:
//   chan_state_e - per-channel FSM encoding (IDLE / HELD / REPEATING)
//   DEF_*        - default timing constants for a 50 MHz clock
package key_input_conditioner_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'b00,
    ST_HELD      = 2'b01,
    ST_REPEATING = 2'b10
  } chan_state_e;

  localparam int unsigned DEF_NUM_KEYS        = 32'd4;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 32'd500000;   // 10 ms
  localparam int unsigned DEF_REPEAT_DELAY    = 32'd25000000; // 0.5 s
  localparam int unsigned DEF_REPEAT_PERIOD   = 32'd5000000;  // 0.1 s
  localparam int unsigned DEF_CNT_W           = 32'd26;

endpackage

// File: rtl/key_input_conditioner_debounce_channel.sv
// One key channel: 2-flop synchronizer, debounce counter, channel FSM and
// hold-to-repeat counter. All outputs are registered.
// Ports:
//   clk, rst       - clock, asynchronous active-low reset
//   key_n_i        - raw active-low key pin (asynchronous)
//   repeat_en_i    - enable for hold-to-repeat pulses
//   level_o        - debounced level, 1 = pressed
//   press_o        - 1-cycle pulse on accepted press
//   release_o      - 1-cycle pulse on accepted release
//   repeat_o       - 1-cycle auto-repeat pulse
//   press_next_o   - next-state value of press_o (feeds the shared any_press flop)
module key_debounce_channel
  import key_input_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
  parameter int unsigned CNT_W           = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n_i,
  input  logic repeat_en_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic repeat_o,
  output logic press_next_o
);

  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 32'd1);
  localparam logic [CNT_W-1:0] RD_LAST  = CNT_W'(REPEAT_DELAY - 32'd1);
  localparam logic [CNT_W-1:0] RP_LAST  = CNT_W'(REPEAT_PERIOD - 32'd1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  logic             sync1_q, sync2_q;
  logic             s_s, accept_s;
  logic [CNT_W-1:0] db_cnt_q, db_cnt_d;
  logic [CNT_W-1:0] rp_cnt_q, rp_cnt_d;
  logic             level_q, level_d;
  chan_state_e      state_q, state_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             repeat_q, repeat_d;

  // Two-flop synchronizer; flops reset to 1 so a reset reads as "released".
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= key_n_i;
      sync2_q <= sync1_q;
    end
  end

  // Debounce: count consecutive cycles where the synchronized key disagrees
  // with the accepted level; any agreeing cycle restarts the count.
  always_comb begin
    s_s      = ~sync2_q;
    accept_s = 1'b0;
    db_cnt_d = db_cnt_q;
    level_d  = level_q;
    if (s_s == level_q) begin
      db_cnt_d = CNT_ZERO;
    end else if (db_cnt_q == DB_LAST) begin
      accept_s = 1'b1;
      db_cnt_d = CNT_ZERO;
      level_d  = ~level_q;
    end else begin
      db_cnt_d = sat_inc(db_cnt_q);
    end
  end

  // Channel FSM and repeat counter; an accepted release takes priority over
  // a repeat that would fire in the same cycle.
  always_comb begin
    state_d   = state_q;
    rp_cnt_d  = rp_cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    repeat_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        rp_cnt_d = CNT_ZERO;
        if (accept_s && s_s) begin
          state_d = ST_HELD;
          press_d = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_HELD, ST_REPEATING: begin
        if (accept_s && !s_s) begin
          state_d   = ST_IDLE;
          release_d = 1'b1;
          rp_cnt_d  = CNT_ZERO;
        end else if (!repeat_en_i) begin
          rp_cnt_d = CNT_ZERO;
        end else if (rp_cnt_q == ((state_q == ST_HELD) ? RD_LAST : RP_LAST)) begin
          state_d  = ST_REPEATING;
          repeat_d = 1'b1;
          rp_cnt_d = CNT_ZERO;
        end else begin
          rp_cnt_d = sat_inc(rp_cnt_q);
        end
      end
      default: begin
        state_d  = ST_IDLE;
        rp_cnt_d = CNT_ZERO;
      end
    endcase
  end

  // State, counter and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      db_cnt_q  <= CNT_ZERO;
      rp_cnt_q  <= CNT_ZERO;
      level_q   <= 1'b0;
      state_q   <= ST_IDLE;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      repeat_q  <= 1'b0;
    end else begin
      db_cnt_q  <= db_cnt_d;
      rp_cnt_q  <= rp_cnt_d;
      level_q   <= level_d;
      state_q   <= state_d;
      press_q   <= press_d;
      release_q <= release_d;
      repeat_q  <= repeat_d;
    end
  end

  assign level_o      = level_q;
  assign press_o      = press_q;
  assign release_o    = release_q;
  assign repeat_o     = repeat_q;
  assign press_next_o = press_d;

endmodule

// File: rtl/key_input_conditioner.sv
// Conditions the active-low push-buttons: synchronize, debounce, and
// produce level / press / release / auto-repeat outputs per key.
// Ports:
//   clk, rst     - clock, asynchronous active-low reset
//   key_n        - raw active-low key pins
//   repeat_en    - per-key hold-to-repeat enable
//   key_level    - debounced level, 1 = pressed
//   key_press    - 1-cycle press pulses
//   key_release  - 1-cycle release pulses
//   key_repeat   - 1-cycle auto-repeat pulses
//   any_press    - OR of key_press (registered, aligned with key_press)
module key_input_conditioner
  import key_input_conditioner_pkg::*;
#(
  parameter int unsigned NUM_KEYS        = DEF_NUM_KEYS,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
  parameter int unsigned CNT_W           = DEF_CNT_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] key_n,
  input  logic [NUM_KEYS-1:0] repeat_en,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_KEYS-1:0] key_repeat,
  output logic                any_press
);

  logic [NUM_KEYS-1:0] press_next_s;
  logic                any_press_q;

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_chan
    key_debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD),
      .CNT_W           (CNT_W)
    ) u_chan (
      .clk          (clk),
      .rst          (rst),
      .key_n_i      (key_n[g]),
      .repeat_en_i  (repeat_en[g]),
      .level_o      (key_level[g]),
      .press_o      (key_press[g]),
      .release_o    (key_release[g]),
      .repeat_o     (key_repeat[g]),
      .press_next_o (press_next_s[g])
    );
  end

  // Registered from the channels' next-state press bits so it lines up
  // with key_press in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      any_press_q <= 1'b0;
    end else begin
      any_press_q <= |press_next_s;
    end
  end

  assign any_press = any_press_q;

endmodule

// File: tb/tb_key_input_conditioner.sv
module tb_key_input_conditioner;

  typedef struct {
    string       tag;
    int          cyc;
    logic [16:0] vec; // {level, press, release, repeat, any}
  } exp_t;

  logic       clk;
  logic       rst;
  logic [3:0] key_n;
  logic [3:0] repeat_en;
  logic [3:0] key_level, key_press, key_release, key_repeat;
  logic       any_press;

  exp_t exp_q[$];
  int   n_assert;
  int   n_fail;

  key_input_conditioner #(
    .NUM_KEYS        (4),
    .DEBOUNCE_CYCLES (4),
    .REPEAT_DELAY    (10),
    .REPEAT_PERIOD   (3),
    .CNT_W           (26)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .key_n       (key_n),
    .repeat_en   (repeat_en),
    .key_level   (key_level),
    .key_press   (key_press),
    .key_release (key_release),
    .key_repeat  (key_repeat),
    .any_press   (any_press)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push_exp(input string tag, input int cyc, input logic [3:0] lv,
                          input logic [3:0] pr, input logic [3:0] rl, input logic [3:0] rp);
    exp_t e;
    e.tag = tag;
    e.cyc = cyc;
    e.vec = {lv, pr, rl, rp, |pr};
    exp_q.push_back(e);
  endtask

  // Expected trace for keys in mask m: press accepted at cycle p, release at
  // cycle r, repeats every 3 cycles from fr (fr<=0: none) strictly before r.
  task automatic plan(input string tag, input logic [3:0] m, input int n,
                      input int p, input int r, input int fr);
    for (int c = 1; c <= n; c++) begin
      logic [3:0] lv, pr, rl, rp;
      lv = (c >= p && c < r) ? m : 4'h0;
      pr = (c == p) ? m : 4'h0;
      rl = (c == r) ? m : 4'h0;
      rp = (fr > 0 && c >= fr && c < r && ((c - fr) % 3) == 0) ? m : 4'h0;
      push_exp(tag, c, lv, pr, rl, rp);
    end
  endtask

  task automatic check_now();
    exp_t        e;
    logic [16:0] obs;
    obs = {key_level, key_press, key_release, key_repeat, any_press};
    n_assert++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty observed %h expected none", obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e.vec) else begin
        n_fail++;
        $error("FAIL %s cyc %0d observed %h expected %h", e.tag, e.cyc, obs, e.vec);
      end
    end
  endtask

  task automatic check_cycle();
    @(posedge clk);
    #1;
    check_now();
  endtask

  initial begin
    n_assert  = 0;
    n_fail    = 0;
    rst       = 1'b0;
    key_n     = 4'h0;
    repeat_en = 4'hF;

    // Reset held with all keys pressed: outputs stay 0.
    for (int c = 1; c <= 3; c++) push_exp("in_reset", c, 4'h0, 4'h0, 4'h0, 4'h0);
    for (int c = 0; c < 3; c++) check_cycle();

    // Reset exit with keys held: press 6 clocks later, then release all.
    rst = 1'b1;
    plan("rst_exit", 4'hF, 16, 6, 14, 16);
    for (int k = 0; k < 16; k++) begin
      if (k == 8) key_n = 4'hF;
      check_cycle();
    end

    // Clean press/release on key 1; release at 46 suppresses the repeat due then.
    plan("clean_k1", 4'h2, 50, 6, 46, 16);
    for (int k = 0; k < 50; k++) begin
      if (k == 0)  key_n[1] = 1'b0;
      if (k == 40) key_n[1] = 1'b1;
      check_cycle();
    end

    // Bounce on key 2: 3 low, 1 high, then steady low.
    plan("bounce_k2", 4'h4, 30, 10, 26, 20);
    for (int k = 0; k < 30; k++) begin
      if (k == 0)  key_n[2] = 1'b0;
      if (k == 3)  key_n[2] = 1'b1;
      if (k == 4)  key_n[2] = 1'b0;
      if (k == 20) key_n[2] = 1'b1;
      check_cycle();
    end

    // Auto-repeat on key 0.
    plan("repeat_k0", 4'h1, 40, 6, 36, 16);
    for (int k = 0; k < 40; k++) begin
      if (k == 0)  key_n[0] = 1'b0;
      if (k == 30) key_n[0] = 1'b1;
      check_cycle();
    end

    // repeat_en gating on key 0, enabled again at cycle 20.
    repeat_en[0] = 1'b0;
    plan("gate_k0", 4'h1, 50, 6, 46, 30);
    for (int k = 0; k < 50; k++) begin
      if (k == 0)  key_n[0] = 1'b0;
      if (k == 20) repeat_en[0] = 1'b1;
      if (k == 40) key_n[0] = 1'b1;
      check_cycle();
    end

    // Reset mid-hold on key 3 while in REPEATING.
    plan("hold_k3", 4'h8, 18, 6, 1000, 16);
    for (int k = 0; k < 18; k++) begin
      if (k == 0) key_n[3] = 1'b0;
      check_cycle();
    end
    rst = 1'b0;
    #1;
    push_exp("rst_async", 0, 4'h0, 4'h0, 4'h0, 4'h0);
    check_now();
    for (int c = 1; c <= 2; c++) push_exp("rst_mid", c, 4'h0, 4'h0, 4'h0, 4'h0);
    for (int c = 0; c < 2; c++) check_cycle();
    rst = 1'b1;
    plan("rst_reentry_k3", 4'h8, 16, 6, 14, 16);
    for (int k = 0; k < 16; k++) begin
      if (k == 8) key_n[3] = 1'b1;
      check_cycle();
    end

    n_assert++;
    assert (exp_q.size() == 0) else begin
      n_fail++;
      $error("FAIL scoreboard_leftover observed %0d expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
